pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the NPC pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Successor to the fixed-field, always-ready stage registers.
- Carries one packed payload bus with a full valid/ready handshake on both sides, synchronous flush, and an optional two-entry skid mode that registers `in_ready` and breaks the ready timing path.
- Includes a saturating back-pressure counter used for stall profiling.

Parameters:
- WIDTH, 64, payload width in bits (≥1).
- SKID, 0, 0 = single-entry stage with combinational ready; 1 = two-entry skid stage with registered `in_ready`.
- RESET_PAYLOAD, {WIDTH{1'b0}}, payload value loaded on reset.
- CNT_W, 32, width of the stall counter (≥1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (branch mispredict / trap).
- in_valid  in  1  upstream has a valid payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload presented downstream.
- stall_clr  in  1  synchronous clear of `stall_cnt`.
- stall_cnt  out  CNT_W  count of cycles with `out_valid` && !`out_ready`.

Behaviour:
- Transfer definitions: in_fire = `in_valid` && `in_ready`; out_fire = `out_valid` && `out_ready`.
- Reset (`rst_n` low, asynchronous):
  - `out_valid` = 0.
  - `out_data` = RESET_PAYLOAD; the skid entry is also RESET_PAYLOAD.
  - `stall_cnt` = 0.
  - `in_ready` = 1.
  - The stage leaves reset on the first rising edge after `rst_n` rises.
  - Reset asserted mid-transfer discards all held payloads immediately.
- SKID=0:
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - On in_fire: data register <= `in_data`; `out_valid` <= 1.
  - Else on out_fire: `out_valid` <= 0.
  - Latency is 1 cycle. Full throughput of 1 per cycle under continuous `out_ready`.
  - `out_data` holds its value while `out_valid` && !`out_ready`.
- SKID=1 state machine:
  - EMPTY: `out_valid`=0, `in_ready`=1.
    - in_fire -> ONE; main <= `in_data`.
  - ONE: `out_valid`=1, `in_ready`=1.
    - in_fire && out_fire -> ONE; main <= `in_data`.
    - in_fire only -> TWO; skid <= `in_data`.
    - out_fire only -> EMPTY.
  - TWO: `out_valid`=1, `in_ready`=0.
    - out_fire -> ONE; main <= skid.
  - `in_ready` is a flop output: (next_state != TWO), registered. It has no combinational path from `out_ready`.
  - `out_data` is always main. Ordering is strictly FIFO. Latency is 1 cycle; throughput is 1 per cycle.
- Flush (both modes):
  - Priority over all handshake activity that cycle. Next state is EMPTY / `out_valid`=0, and `in_ready` becomes 1 next cycle.
  - Any in_fire in the flush cycle is discarded.
  - Payload registers are not cleared.
  - If flush and out_fire occur in the same cycle, downstream still sees that cycle's transfer as valid.
- Stall counter:
  - Increments by 1 each cycle `out_valid` && !`out_ready`.
  - Saturates at 2^CNT_W−1 with no wrap.
  - `stall_clr` sets it to 0 and takes priority over increment.
  - Flush does not affect the counter.
- Invariant: while `out_valid` && !`out_ready`, `out_valid` and `out_data` do not change unless flush or reset is asserted.

Decomposition:
- Shared package `npc_pipe_pkg`: `PIPE_SKID_OFF`/`PIPE_SKID_ON` constants and the SKID-mode state encoding (`PS_EMPTY`=2'd0, `PS_ONE`=2'd1, `PS_TWO`=2'd2).
- Stage payload struct/width constants per stage (e.g. `MEM_WB_W`) also live in the package.
- Sub-module: `sat_counter` (CNT_W, inc, clr, async active-low reset), instanced for `stall_cnt`.
- Data storage is built from the existing Reg primitive or from plain always blocks. Both SKID variants are selected by generate.

Test Plan:
- Reset: hold `rst_n`=0 with RESET_PAYLOAD=64'hDEAD, toggle `in_valid`=1 -> `out_valid`=0, `out_data`=64'hDEAD, `stall_cnt`=0, `in_ready`=1; release -> first accepted word appears 1 cycle after in_fire.
- Streaming, both SKID values: 100 words 0..99 with `out_ready`=1 constantly -> 100 out_fires in 101 cycles, in order, no gaps.
- Back-pressure, SKID=1: send A,B,C with `out_ready`=0 -> A in main, B in skid, `in_ready`=0 the cycle after B is accepted, C held upstream; raise `out_ready` -> A, B, C delivered in order, `stall_cnt`=number of stalled cycles (e.g. 3).
- SKID=0 ready path: `out_valid`=1, `out_ready` toggles 1/0/1 -> `in_ready` tracks `out_ready` in the same cycle; no payload lost or duplicated (scoreboard).
- Flush in state TWO with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1; both held words and the flush-cycle input are never delivered; the next word, 0x55, is delivered alone.
- Counter: CNT_W=4, stall 20 cycles -> `stall_cnt`=15 (saturated); `stall_clr` asserted during a stall -> 0 the next cycle, then increments from 1.

Source files
------------

// File: rtl/npc_pipe_pkg.sv
// npc_pipe_pkg: shared pipeline-stage constants, SKID-mode state encoding, stage payload widths.
// Revision: 1.0
`default_nettype none
package npc_pipe_pkg;

  localparam int PIPE_SKID_OFF = 0;
  localparam int PIPE_SKID_ON  = 1;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [63:0] alu_res;
    logic [63:0] store_val;
    logic [4:0]  rd;
    logic [3:0]  mem_ctrl;
    logic        wb_en;
  } ex_mem_t;

  typedef struct packed {
    logic [63:0] wb_data;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear wins over increment).
// Revision: 1.0
`default_nettype none
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline register with optional two-entry skid mode,
// synchronous flush and a saturating back-pressure counter.  Revision: 1.0
`default_nettype none
module pipe_stage_reg
  import npc_pipe_pkg::*;
#(
  parameter int               WIDTH         = 64,
  parameter int               SKID          = 0,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
  parameter int               CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  generate
    if (SKID == PIPE_SKID_OFF) begin : g_single
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic             in_fire;

      assign in_ready = !valid_q || out_ready;
      assign in_fire  = in_valid && in_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= RESET_PAYLOAD;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_fire) begin
          valid_q <= 1'b1;
          data_q  <= in_data;
        end else if (out_ready) begin
          valid_q <= 1'b0;
        end
      end

      assign out_valid = valid_q;
      assign out_data  = data_q;
    end else begin : g_skid
      pipe_state_e      state_q;
      logic [WIDTH-1:0] main_q;
      logic [WIDTH-1:0] skid_q;
      logic             rdy_q;
      logic             in_fire;

      assign in_fire = in_valid && rdy_q;

      // rdy_q is loaded with (next state != TWO) in every branch, so in_ready never sees out_ready combinationally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= PS_EMPTY;
          main_q  <= RESET_PAYLOAD;
          skid_q  <= RESET_PAYLOAD;
          rdy_q   <= 1'b1;
        end else if (flush) begin
          state_q <= PS_EMPTY;
          rdy_q   <= 1'b1;
        end else begin
          case (state_q)
            PS_EMPTY: begin
              rdy_q <= 1'b1;
              if (in_fire) begin
                main_q  <= in_data;
                state_q <= PS_ONE;
              end
            end
            PS_ONE: begin
              if (in_fire && out_ready) begin
                main_q <= in_data;
                rdy_q  <= 1'b1;
              end else if (in_fire) begin
                skid_q  <= in_data;
                state_q <= PS_TWO;
                rdy_q   <= 1'b0;
              end else if (out_ready) begin
                state_q <= PS_EMPTY;
                rdy_q   <= 1'b1;
              end
            end
            PS_TWO: begin
              if (out_ready) begin
                main_q  <= skid_q;
                state_q <= PS_ONE;
                rdy_q   <= 1'b1;
              end
            end
            default: begin
              state_q <= PS_EMPTY;
              rdy_q   <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state_q != PS_EMPTY);
      assign out_data  = main_q;
    end
  endgenerate

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .clr   (stall_clr),
    .cnt   (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench; instance a is SKID=0/CNT_W=4, instance b is SKID=1/CNT_W=8.
// Revision: 1.0
`default_nettype none
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall_clr;
  logic [63:0] a_in_data, a_out_data;
  logic [3:0]  a_stall_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
  logic [63:0] b_in_data, b_out_data;
  logic [7:0]  b_stall_cnt;

  pipe_stage_reg #(
    .WIDTH(64), .SKID(0), .RESET_PAYLOAD(64'hDEAD), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_clr(a_stall_clr), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(
    .WIDTH(64), .SKID(1), .RESET_PAYLOAD(64'hDEAD), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_clr(b_stall_clr), .stall_cnt(b_stall_cnt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic        sel;
  logic        m_in_ready, m_out_valid;
  logic [63:0] m_out_data;
  logic [31:0] m_stall;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_stall     = sel ? 32'(b_stall_cnt) : 32'(a_stall_cnt);

  task automatic drv(input logic v, input logic [63:0] d, input logic r,
                     input logic f, input logic c);
    if (sel) begin
      b_in_valid = v; b_in_data = d; b_out_ready = r; b_flush = f; b_stall_clr = c;
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b0; a_stall_clr = 1'b0;
    end else begin
      a_in_valid = v; a_in_data = d; a_out_ready = r; a_flush = f; a_stall_clr = c;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0; b_stall_clr = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h1111; a_out_ready = 1'b0; a_flush = 1'b0; a_stall_clr = 1'b0;
    b_in_valid = 1'b1; b_in_data = 64'h2222; b_out_ready = 1'b0; b_flush = 1'b0; b_stall_clr = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_a_valid got=%b exp=0", a_out_valid); end
    vec_cnt++; if (a_out_data !== 64'hDEAD) begin err_cnt++; $display("FAIL rst_a_data got=%h exp=dead", a_out_data); end
    vec_cnt++; if (a_stall_cnt !== 4'd0) begin err_cnt++; $display("FAIL rst_a_cnt got=%0d exp=0", a_stall_cnt); end
    vec_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_a_ready got=%b exp=1", a_in_ready); end
    vec_cnt++; if (b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_b_valid got=%b exp=0", b_out_valid); end
    vec_cnt++; if (b_out_data !== 64'hDEAD) begin err_cnt++; $display("FAIL rst_b_data got=%h exp=dead", b_out_data); end
    vec_cnt++; if (b_stall_cnt !== 8'd0) begin err_cnt++; $display("FAIL rst_b_cnt got=%0d exp=0", b_stall_cnt); end
    vec_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_b_ready got=%b exp=1", b_in_ready); end
    rst_n = 1'b1;
    sel = 1'b0;
    drv(1'b1, 64'h1234, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drv(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    vec_cnt++; if (a_out_valid !== 1'b1) begin err_cnt++; $display("FAIL rel_valid got=%b exp=1", a_out_valid); end
    vec_cnt++; if (a_out_data !== 64'h1234) begin err_cnt++; $display("FAIL rel_data got=%h exp=1234", a_out_data); end
    @(negedge clk);
    vec_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rel_drain got=%b exp=0", a_out_valid); end
    drain();
  endtask

  task automatic test_stream(input logic s);
    int exp_w = 0;
    int fires = 0;
    sel = s;
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      if (m_out_valid) begin
        vec_cnt++;
        if (m_out_data !== 64'(exp_w)) begin
          err_cnt++; $display("FAIL stream%0d_data got=%0d exp=%0d", s, m_out_data, exp_w);
        end
        exp_w++; fires++;
      end
      drv(c < 100, 64'(c), 1'b1, 1'b0, 1'b0);
      #1;
      if (c < 100) begin
        vec_cnt++;
        if (m_in_ready !== 1'b1) begin err_cnt++; $display("FAIL stream%0d_ready c=%0d got=%b exp=1", s, c, m_in_ready); end
      end
    end
    vec_cnt++;
    if (fires !== 100) begin err_cnt++; $display("FAIL stream%0d_fires got=%0d exp=100", s, fires); end
    drain();
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    @(negedge clk); drv(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    vec_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready0 got=%b exp=1", b_in_ready); end
    drv(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_data !== 64'hA || b_out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_mainA got=%h/%b exp=a/1", b_out_data, b_out_valid); end
    vec_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready1 got=%b exp=1", b_in_ready); end
    drv(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_full got=%b exp=0", b_in_ready); end
    vec_cnt++; if (b_out_data !== 64'hA) begin err_cnt++; $display("FAIL bp_holdA got=%h exp=a", b_out_data); end
    drv(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drv(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_stall_cnt !== 8'd3) begin err_cnt++; $display("FAIL bp_cnt got=%0d exp=3", b_stall_cnt); end
    vec_cnt++; if (b_out_data !== 64'hA) begin err_cnt++; $display("FAIL bp_outA got=%h exp=a", b_out_data); end
    drv(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_data !== 64'hB) begin err_cnt++; $display("FAIL bp_outB got=%h exp=b", b_out_data); end
    vec_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready2 got=%b exp=1", b_in_ready); end
    drv(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_data !== 64'hC || b_out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_outC got=%h/%b exp=c/1", b_out_data, b_out_valid); end
    drv(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_empty got=%b exp=0", b_out_valid); end
    vec_cnt++; if (b_stall_cnt !== 8'd3) begin err_cnt++; $display("FAIL bp_cnt_end got=%0d exp=3", b_stall_cnt); end
    drain();
  endtask

  task automatic test_ready_path();
    logic [63:0] sb[$];
    logic        pat[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_rdy;
    logic [63:0] k = 64'h100;
    logic [63:0] w;
    sel = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drv(c < 7, k, (c < 7) ? pat[c] : 1'b1, 1'b0, 1'b0);
      #1;
      exp_rdy = !a_out_valid || a_out_ready;
      vec_cnt++;
      if (a_in_ready !== exp_rdy) begin err_cnt++; $display("FAIL rp_ready c=%0d got=%b exp=%b", c, a_in_ready, exp_rdy); end
      if (a_out_valid && a_out_ready) begin
        vec_cnt++;
        if (sb.size() == 0) begin
          err_cnt++; $display("FAIL rp_dup got=%h exp=none", a_out_data);
        end else begin
          w = sb.pop_front();
          if (a_out_data !== w) begin err_cnt++; $display("FAIL rp_data got=%h exp=%h", a_out_data, w); end
        end
      end
      if (a_in_valid && a_in_ready) begin
        sb.push_back(k);
        k++;
      end
    end
    vec_cnt++;
    if (sb.size() != 0) begin err_cnt++; $display("FAIL rp_lost got=%0d exp=0", sb.size()); end
    drain();
  endtask

  task automatic test_flush();
    sel = 1'b1;
    @(negedge clk); drv(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_in_ready !== 1'b0) begin err_cnt++; $display("FAIL fl_two got=%b exp=0", b_in_ready); end
    drv(1'b1, 64'h33, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_valid got=%b exp=0", b_out_valid); end
    vec_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL fl_ready got=%b exp=1", b_in_ready); end
    drv(1'b1, 64'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_valid !== 1'b1 || b_out_data !== 64'h55) begin err_cnt++; $display("FAIL fl_next got=%h/%b exp=55/1", b_out_data, b_out_valid); end
    drv(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_alone got=%b exp=0", b_out_valid); end
    drain();
  endtask

  task automatic test_counter();
    sel = 1'b0;
    @(negedge clk); drv(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); drv(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drv(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    vec_cnt++; if (a_stall_cnt !== 4'd15) begin err_cnt++; $display("FAIL cnt_sat got=%0d exp=15", a_stall_cnt); end
    vec_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h77) begin err_cnt++; $display("FAIL cnt_hold got=%h/%b exp=77/1", a_out_data, a_out_valid); end
    drv(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vec_cnt++; if (a_stall_cnt !== 4'd0) begin err_cnt++; $display("FAIL cnt_clr got=%0d exp=0", a_stall_cnt); end
    drv(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vec_cnt++; if (a_stall_cnt !== 4'd1) begin err_cnt++; $display("FAIL cnt_inc got=%0d exp=1", a_stall_cnt); end
    drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    vec_cnt++; if (a_stall_cnt !== 4'd2 || a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL cnt_flush got=%0d/%b exp=2/0", a_stall_cnt, a_out_valid); end
    drain();
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_backpressure();
    test_ready_path();
    test_flush();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
